// File: rtl/au_dec_b_pipe_if.sv
// rtl/au_dec_b_pipe_if.sv - valid/ready operand and result channels of the pipelined decrementer
interface au_dec_b_pipe_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic             bi;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] z;
   logic             bo;

   modport master (
      output in_valid, a, bi, out_ready,
      input  in_ready, out_valid, z, bo
   );

   modport slave (
      input  in_valid, a, bi, out_ready,
      output in_ready, out_valid, z, bo
   );
endinterface

// File: rtl/au_dec_b_pipe.sv
// rtl/au_dec_b_pipe.sv - segmented z = a - bi, one SEG-bit segment resolved per stage
// The borrow ripples stage to stage; the whole pipe advances or holds as one unit.
module au_dec_b_pipe #(
   parameter int WIDTH = 32,
   parameter int SEG   = 8
) (
   input  logic           clk,
   input  logic           rst,
   au_dec_b_pipe_if.slave io
);
   localparam int SEG_C    = (SEG < 1) ? 1 : SEG;
   localparam int NSTG_RAW = (WIDTH + SEG_C - 1) / SEG_C;
   localparam int NSTG     = (NSTG_RAW < 1) ? 1 : NSTG_RAW;

   if (WIDTH < 1 || SEG < 1 || SEG > WIDTH) begin : g_bad_param
      $fatal(1, "ERROR: %m illegal parameters WIDTH=%0d SEG=%0d", WIDTH, SEG);
   end

   logic             s_v   [NSTG];
   logic [WIDTH-1:0] s_w   [NSTG];
   logic             s_b   [NSTG];
   logic [WIDTH-1:0] nxt_w [NSTG];
   logic             nxt_b [NSTG];
   logic             adv;

   assign adv         = !s_v[NSTG-1] | io.out_ready;
   assign io.in_ready = rst | adv;

   for (genvar k = 0; k < NSTG; k++) begin : g_stg
      localparam int LO = k * SEG_C;
      localparam int SW = (k == NSTG - 1) ? WIDTH - LO : SEG_C;

      logic [WIDTH-1:0] w_in;
      logic             b_in;
      logic [SW-1:0]    seg;
      logic [WIDTH-1:0] w_nxt;

      if (k == 0) begin : g_first
         assign w_in = io.a;
         assign b_in = io.bi;
      end else begin : g_next
         assign w_in = s_w[k-1];
         assign b_in = s_b[k-1];
      end

      assign seg = w_in[LO +: SW];

      // only segment k changes; lower ones are already final, upper ones still raw
      always_comb begin
         w_nxt             = w_in;
         w_nxt[LO +: SW]   = seg - SW'(b_in);
      end

      assign nxt_w[k] = w_nxt;
      assign nxt_b[k] = b_in & (seg == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NSTG; k++) begin
            s_v[k] <= 1'b0;
            s_w[k] <= '0;
            s_b[k] <= 1'b0;
         end
      end else if (adv) begin
         s_v[0] <= io.in_valid;
         for (int k = 1; k < NSTG; k++) begin
            s_v[k] <= s_v[k-1];
         end
         for (int k = 0; k < NSTG; k++) begin
            s_w[k] <= nxt_w[k];
            s_b[k] <= nxt_b[k];
         end
      end
   end

   assign io.out_valid = s_v[NSTG-1];
   assign io.z         = s_w[NSTG-1];
   assign io.bo        = s_b[NSTG-1];
endmodule

// File: tb/tb_au_dec_b_pipe.sv
// tb/tb_au_dec_b_pipe.sv - directed and randomized checks of the pipelined decrementer
module tb_au_dec_b_pipe;
   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   au_dec_b_pipe_if #(.WIDTH(32)) mif ();
   au_dec_b_pipe #(.WIDTH(32), .SEG(8)) dut (.clk(clk), .rst(rst), .io(mif.slave));

   logic [32:0] m_q [$];
   int          m_acc = 0;
   int          m_rx  = 0;

   always @(negedge clk) begin
      if (rst) begin
         m_q.delete();
      end else begin
         if (mif.out_valid && mif.out_ready) begin
            check_eq("sb_pending", 64'(m_q.size() != 0), 64'h1);
            if (m_q.size() != 0) check_eq("sb_data", 64'({mif.bo, mif.z}), 64'(m_q.pop_front()));
            m_rx++;
         end
         if (mif.in_valid && mif.in_ready) begin
            m_q.push_back({1'b0, mif.a} - 33'(mif.bi));
            m_acc++;
         end
      end
   end

   bit sweep_go   = 1'b0;
   int sweep_done = 0;

   for (genvar g = 0; g < 3; g++) begin : g_sw
      localparam int W = (g == 0) ? 1 : (g == 1) ? 7 : 33;
      localparam int S = (g == 0) ? 1 : (g == 1) ? 3 : 8;

      au_dec_b_pipe_if #(.WIDTH(W)) sif ();
      au_dec_b_pipe #(.WIDTH(W), .SEG(S)) sdut (.clk(clk), .rst(rst), .io(sif.slave));

      logic [W:0] q [$];
      int         sent = 0;
      int         rcvd = 0;

      initial begin
         sif.in_valid  = 1'b0;
         sif.a         = '0;
         sif.bi        = 1'b0;
         sif.out_ready = 1'b0;
         wait (sweep_go);
         for (int t = 0; t < 400 && rcvd < 60; t++) begin
            sif.in_valid  = (sent < 60) && ($urandom_range(0, 3) != 0);
            sif.a         = W'({$urandom, $urandom});
            if ($urandom_range(0, 7) == 0) sif.a = '0;
            sif.bi        = 1'($urandom_range(0, 1));
            sif.out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (sif.out_valid && sif.out_ready) begin
               check_eq($sformatf("sw_w%0d_pending", W), 64'(q.size() != 0), 64'h1);
               if (q.size() != 0)
                  check_eq($sformatf("sw_w%0d_data", W), 64'({sif.bo, sif.z}), 64'(q.pop_front()));
               rcvd++;
            end
            if (sif.in_valid && sif.in_ready) begin
               q.push_back({1'b0, sif.a} - (W+1)'(sif.bi));
               sent++;
            end
            step();
         end
         sif.in_valid = 1'b0;
         check_eq($sformatf("sw_w%0d_count", W), 64'(rcvd), 64'd60);
         sweep_done++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          acc0;
      int          rx0;
      logic [31:0] hz;
      logic        hb;

      rst           = 1'b1;
      mif.in_valid  = 1'b0;
      mif.a         = '0;
      mif.bi        = 1'b0;
      mif.out_ready = 1'b1;
      @(negedge clk);
      check_eq("rst_in_ready", 64'(mif.in_ready), 64'h1);
      step();
      step();
      check_eq("rst_out_valid", 64'(mif.out_valid), 64'h0);
      check_eq("rst_z", 64'(mif.z), 64'h0);
      check_eq("rst_bo", 64'(mif.bo), 64'h0);
      rst = 1'b0;

      // basic: 0x100 - 1, four-stage latency
      mif.in_valid = 1'b1;
      mif.a        = 32'h0000_0100;
      mif.bi       = 1'b1;
      step();
      mif.in_valid = 1'b0;
      step();
      step();
      check_eq("lat_early", 64'(mif.out_valid), 64'h0);
      step();
      check_eq("lat_valid", 64'(mif.out_valid), 64'h1);
      check_eq("basic_z", 64'(mif.z), 64'h0000_00FF);
      check_eq("basic_bo", 64'(mif.bo), 64'h0);

      // wrap-around, then bi = 0 on zero
      mif.in_valid = 1'b1;
      mif.a        = 32'h0;
      mif.bi       = 1'b1;
      step();
      mif.bi       = 1'b0;
      step();
      mif.in_valid = 1'b0;
      step();
      step();
      check_eq("wrap_valid", 64'(mif.out_valid), 64'h1);
      check_eq("wrap_z", 64'(mif.z), 64'hFFFF_FFFF);
      check_eq("wrap_bo", 64'(mif.bo), 64'h1);
      step();
      check_eq("zero_valid", 64'(mif.out_valid), 64'h1);
      check_eq("zero_z", 64'(mif.z), 64'h0);
      check_eq("zero_bo", 64'(mif.bo), 64'h0);
      step();

      // streaming: 100 back-to-back words
      acc0 = m_acc;
      rx0  = m_rx;
      for (int i = 0; i < 100; i++) begin
         mif.in_valid = 1'b1;
         mif.a        = (i % 10 == 0) ? 32'h0 : $urandom;
         mif.bi       = 1'($urandom_range(0, 1));
         step();
      end
      mif.in_valid = 1'b0;
      repeat (4) step();
      check_eq("stream_acc", 64'(m_acc - acc0), 64'd100);
      check_eq("stream_rx", 64'(m_rx - rx0), 64'd100);
      check_eq("stream_idle", 64'(mif.out_valid), 64'h0);

      // backpressure: out_ready low for 6 cycles mid-stream
      acc0 = m_acc;
      rx0  = m_rx;
      fork
         begin : src
            logic rdy;
            for (int i = 0; i < 20; i++) begin
               mif.in_valid = 1'b1;
               mif.a        = $urandom;
               mif.bi       = 1'($urandom_range(0, 1));
               for (int t = 0; t < 50; t++) begin
                  @(negedge clk);
                  rdy = mif.in_ready;
                  step();
                  if (rdy) break;
               end
            end
            mif.in_valid = 1'b0;
         end
         begin : sink
            repeat (8) step();
            mif.out_ready = 1'b0;
            @(negedge clk);
            hz = mif.z;
            hb = mif.bo;
            check_eq("bp_out_valid", 64'(mif.out_valid), 64'h1);
            check_eq("bp_in_ready", 64'(mif.in_ready), 64'h0);
            for (int i = 1; i < 6; i++) begin
               @(negedge clk);
               check_eq("bp_in_ready", 64'(mif.in_ready), 64'h0);
               check_eq("bp_z_hold", 64'(mif.z), 64'(hz));
               check_eq("bp_bo_hold", 64'(mif.bo), 64'(hb));
            end
            step();
            mif.out_ready = 1'b1;
         end
      join
      repeat (6) step();
      check_eq("bp_acc", 64'(m_acc - acc0), 64'd20);
      check_eq("bp_rx", 64'(m_rx - rx0), 64'd20);
      check_eq("bp_drained", 64'(m_q.size()), 64'd0);

      // reset with three words in flight; input during reset must be dropped
      mif.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         mif.a  = 32'hA000_0000 + 32'(i);
         mif.bi = 1'b1;
         step();
      end
      rst    = 1'b1;
      mif.a  = 32'h0000_DEAD;
      @(negedge clk);
      check_eq("rst_mid_in_ready", 64'(mif.in_ready), 64'h1);
      step();
      rst          = 1'b0;
      mif.in_valid = 1'b0;
      check_eq("rst_flush", 64'(mif.out_valid), 64'h0);
      rx0 = m_rx;
      mif.in_valid = 1'b1;
      mif.a        = 32'h1234_0000;
      mif.bi       = 1'b1;
      step();
      mif.in_valid = 1'b0;
      step();
      step();
      check_eq("post_rst_early", 64'(mif.out_valid), 64'h0);
      step();
      check_eq("post_rst_valid", 64'(mif.out_valid), 64'h1);
      check_eq("post_rst_z", 64'(mif.z), 64'h1233_FFFF);
      check_eq("post_rst_bo", 64'(mif.bo), 64'h0);
      repeat (3) step();
      check_eq("post_rst_alone", 64'(m_rx - rx0), 64'd1);

      // parameter sweep runs on its own instances
      sweep_go = 1'b1;
      for (int t = 0; t < 2000 && sweep_done < 3; t++) step();
      check_eq("sweep_done", 64'(sweep_done), 64'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
